// File: rtl/branch_cmp_seq_pkg.sv
// ============================================================================
// Module   : branch_cmp_seq_pkg
// Brief    : Mode/state encodings and branch-decision helpers for branch_cmp_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_cmp_seq_pkg;

    localparam logic [2:0] CMP_EQ  = 3'd0;
    localparam logic [2:0] CMP_NE  = 3'd1;
    localparam logic [2:0] CMP_LTZ = 3'd2;
    localparam logic [2:0] CMP_GEZ = 3'd3;
    localparam logic [2:0] CMP_LEZ = 3'd4;
    localparam logic [2:0] CMP_GTZ = 3'd5;
    localparam logic [2:0] CMP_LT  = 3'd6;
    localparam logic [2:0] CMP_LTU = 3'd7;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Compare-against-zero modes ignore operand B.
    function automatic logic is_zero_mode(input logic [2:0] m);
        return (m == CMP_LTZ) || (m == CMP_GEZ) || (m == CMP_LEZ) || (m == CMP_GTZ);
    endfunction

    function automatic logic taken_decode(input logic [2:0] m, input logic eq, input logic lt);
        logic t;
        case (m)
            CMP_EQ:  t = eq;
            CMP_NE:  t = ~eq;
            CMP_LTZ: t = lt;
            CMP_GEZ: t = ~lt;
            CMP_LEZ: t = lt | eq;
            CMP_GTZ: t = ~lt & ~eq;
            default: t = lt;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cmp_seq_if.sv
// ============================================================================
// Module   : branch_cmp_seq_if
// Brief    : Request/result bundle between the D stage and branch_cmp_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface branch_cmp_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             stall;
    logic             done;
    logic             eq;
    logic             lt;
    logic             taken;

    modport master (
        output start, mode, a, b, flush,
        input  ready, stall, done, eq, lt, taken
    );

    modport slave (
        input  start, mode, a, b, flush,
        output ready, stall, done, eq, lt, taken
    );
endinterface

`default_nettype wire

// File: rtl/branch_cmp_seq_cmp_slice.sv
// ============================================================================
// Module   : cmp_slice
// Brief    : Combinational CHUNK-bit slice compare with optional MSB inversion.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmp_slice #(
    parameter int CHUNK = 8
) (
    input  wire logic [CHUNK-1:0] sa,
    input  wire logic [CHUNK-1:0] sb,
    input  wire logic             inv_msb,
    output logic                  s_eq,
    output logic                  s_lt
);
    // Flipping the sign bit turns a signed compare into an unsigned one.
    logic [CHUNK-1:0] w_flip;
    logic [CHUNK-1:0] w_xa;
    logic [CHUNK-1:0] w_xb;

    always_comb begin
        w_flip          = '0;
        w_flip[CHUNK-1] = inv_msb;
        w_xa            = sa ^ w_flip;
        w_xb            = sb ^ w_flip;
        s_eq            = (w_xa == w_xb);
        s_lt            = (w_xa < w_xb);
    end
endmodule

`default_nettype wire

// File: rtl/branch_cmp_seq.sv
// ============================================================================
// Module   : branch_cmp_seq
// Brief    : Sequential MSB-first sliced branch comparator with early exit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_cmp_seq
    import branch_cmp_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    branch_cmp_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_param_check
        $error("branch_cmp_seq: WIDTH must be a multiple of CHUNK");
    end

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_mode;
    logic             r_dec;
    logic             r_lt_w;
    logic             r_done;
    logic             r_eq;
    logic             r_lt;
    logic             r_taken;

    logic             w_accept;
    logic             w_finish;
    logic             w_first_diff;
    logic             w_dec_nxt;
    logic             w_lt_nxt;
    logic             w_inv;
    logic             w_s_eq;
    logic             w_s_lt;
    logic [CHUNK-1:0] w_a_sl [NCHUNK];
    logic [CHUNK-1:0] w_b_sl [NCHUNK];

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
        assign w_a_sl[gi] = r_a[gi*CHUNK +: CHUNK];
        assign w_b_sl[gi] = r_b[gi*CHUNK +: CHUNK];
    end

    assign w_inv = (r_idx == IDXW'(NCHUNK - 1)) && (r_mode != CMP_LTU);

    cmp_slice #(
        .CHUNK   (CHUNK)
    ) u_slice (
        .sa      (w_a_sl[r_idx]),
        .sb      (w_b_sl[r_idx]),
        .inv_msb (w_inv),
        .s_eq    (w_s_eq),
        .s_lt    (w_s_lt)
    );

    // Only the first differing slice decides lt; later slices are irrelevant.
    assign w_accept     = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_first_diff = !r_dec && !w_s_eq;
    assign w_dec_nxt    = r_dec || !w_s_eq;
    assign w_lt_nxt     = w_first_diff ? w_s_lt : r_lt_w;
    assign w_finish     = (r_state == S_RUN) && !bus.flush &&
                          ((r_idx == '0) || ((EARLY_EXIT != 0) && w_first_diff));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (bus.flush || w_finish) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (r_state == S_IDLE);
        bus.stall = (r_state == S_RUN) || w_accept;
        bus.done  = r_done;
        bus.eq    = r_eq;
        bus.lt    = r_lt;
        bus.taken = r_taken;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= '0;
            r_dec   <= 1'b0;
            r_lt_w  <= 1'b0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_taken <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a    <= bus.a;
                r_b    <= is_zero_mode(bus.mode) ? '0 : bus.b;
                r_mode <= bus.mode;
                r_idx  <= IDXW'(NCHUNK - 1);
                r_dec  <= 1'b0;
                r_lt_w <= 1'b0;
            end else if ((r_state == S_RUN) && !bus.flush) begin
                r_dec  <= w_dec_nxt;
                r_lt_w <= w_lt_nxt;
                if (r_idx != '0) begin
                    r_idx <= r_idx - IDXW'(1);
                end
                if (w_finish) begin
                    r_done  <= 1'b1;
                    r_eq    <= !w_dec_nxt;
                    r_lt    <= w_lt_nxt;
                    r_taken <= taken_decode(r_mode, !w_dec_nxt, w_lt_nxt);
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_branch_cmp_seq.sv
// ============================================================================
// Module   : tb_branch_cmp_seq
// Brief    : Directed vector table plus hand sequences for branch_cmp_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_cmp_seq;
    import branch_cmp_seq_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    branch_cmp_seq_if #(.WIDTH(32)) bus  ();
    branch_cmp_seq_if #(.WIDTH(32)) bus2 ();

    branch_cmp_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    branch_cmp_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut_full (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    typedef struct {
        logic [2:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        logic        eq;
        logic        lt;
        logic        tk;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one op on the EARLY_EXIT=1 DUT and wait (bounded) for done.
    task automatic run_op(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                          output int k, output logic eq, output logic lt, output logic tk,
                          output bit sok);
        bus.mode  = m;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        k   = -1;
        sok = 1'b1;
        #1;
        if (bus.stall !== 1'b1 || bus.ready !== 1'b1) sok = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.mode  = m ^ 3'd1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                k = c;
                break;
            end
            if (bus.stall !== 1'b1) sok = 1'b0;
        end
        if (k > 0 && bus.stall !== 1'b0) sok = 1'b0;
        eq = bus.eq;
        lt = bus.lt;
        tk = bus.taken;
    endtask

    initial begin
        int   k;
        int   ndone;
        logic eq, lt, tk;
        bit   sok;

        vecs[0]  = '{CMP_EQ,  32'h12345678, 32'h12345678, 4, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{CMP_LT,  32'h80000000, 32'h00000001, 1, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{CMP_LTU, 32'h80000000, 32'h00000001, 1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{CMP_LEZ, 32'hFFFFFFFF, 32'h00000005, 1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{CMP_GTZ, 32'h00000000, 32'h00001234, 4, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{CMP_NE,  32'h12345678, 32'h12345679, 4, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{CMP_LT,  32'h00010000, 32'h00020000, 2, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{CMP_GEZ, 32'h7FFFFFFF, 32'h00000000, 1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{CMP_LT,  32'h00000005, 32'hFFFFFFFD, 1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{CMP_LTU, 32'h00FF0000, 32'h00FE0000, 2, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{CMP_LEZ, 32'h00000000, 32'hFFFFFFFF, 4, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{CMP_GTZ, 32'h00000001, 32'h00000000, 4, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{CMP_EQ,  32'h00000001, 32'h00000002, 4, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{CMP_GEZ, 32'h80000000, 32'h00000000, 1, 1'b0, 1'b1, 1'b0};

        bus.start  = 1'b0; bus.flush  = 1'b0; bus.mode  = '0; bus.a  = '0; bus.b  = '0;
        bus2.start = 1'b0; bus2.flush = 1'b0; bus2.mode = '0; bus2.a = '0; bus2.b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst.ready", {31'd0, bus.ready}, 32'd1);
        check("rst.stall", {31'd0, bus.stall}, 32'd0);
        check("rst.flags", {28'd0, bus.done, bus.eq, bus.lt, bus.taken}, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].m, vecs[i].a, vecs[i].b, k, eq, lt, tk, sok);
            check($sformatf("v%0d.k", i), k, vecs[i].k);
            check($sformatf("v%0d.eq", i), {31'd0, eq}, {31'd0, vecs[i].eq});
            check($sformatf("v%0d.lt", i), {31'd0, lt}, {31'd0, vecs[i].lt});
            check($sformatf("v%0d.taken", i), {31'd0, tk}, {31'd0, vecs[i].tk});
            check($sformatf("v%0d.stall", i), {31'd0, sok}, 32'd1);
        end

        // Flush in the second RUN cycle: no done, previous result (vecs[13]) kept.
        bus.mode = CMP_EQ; bus.a = 32'd1; bus.b = 32'd1; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        check("flush.ready", {31'd0, bus.ready}, 32'd1);
        check("flush.done", {31'd0, bus.done}, 32'd0);
        check("flush.held", {29'd0, bus.eq, bus.lt, bus.taken},
              {29'd0, vecs[13].eq, vecs[13].lt, vecs[13].tk});
        ndone = 0;
        repeat (6) begin @(posedge clk); #1 if (bus.done === 1'b1) ndone++; end
        check("flush.nodone", ndone, 0);

        // start together with flush in IDLE is refused.
        bus.start = 1'b1; bus.flush = 1'b1;
        #1 check("flush_start.stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start.ready", {31'd0, bus.ready}, 32'd1);
        ndone = 0;
        repeat (6) begin @(posedge clk); #1 if (bus.done === 1'b1) ndone++; end
        check("flush_start.nodone", ndone, 0);

        // Back-to-back: second start issued in the done cycle of the first.
        run_op(CMP_LT, 32'h80000000, 32'h00000001, k, eq, lt, tk, sok);
        check("b2b.k1", k, 1);
        run_op(CMP_EQ, 32'hCAFE0000, 32'hCAFE0000, k, eq, lt, tk, sok);
        check("b2b.k2", k, 4);
        check("b2b.res", {29'd0, eq, lt, tk}, {29'd0, 1'b1, 1'b0, 1'b1});

        // start pulsed mid-RUN is ignored.
        bus.mode = CMP_EQ; bus.a = 32'h0000AAAA; bus.b = 32'h0000AAAA; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1;
        bus.mode = CMP_NE; bus.a = 32'd1; bus.b = 32'd2; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        ndone = 0;
        tk = 1'b0; eq = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin ndone++; eq = bus.eq; tk = bus.taken; end
        end
        check("midrun.ndone", ndone, 1);
        check("midrun.res", {30'd0, eq, tk}, 32'd3);

        // Async reset between edges mid-RUN.
        bus.mode = CMP_EQ; bus.a = 32'h55; bus.b = 32'h55; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        #1;
        check("areset.ready", {31'd0, bus.ready}, 32'd1);
        check("areset.flags", {28'd0, bus.done, bus.eq, bus.lt, bus.taken}, 32'd0);
        #1 reset = 1'b0;
        run_op(vecs[6].m, vecs[6].a, vecs[6].b, k, eq, lt, tk, sok);
        check("areset.fresh_k", k, vecs[6].k);
        check("areset.fresh_res", {29'd0, eq, lt, tk}, {29'd0, vecs[6].eq, vecs[6].lt, vecs[6].tk});

        // EARLY_EXIT=0 instance always takes NCHUNK cycles.
        @(negedge clk);
        bus2.mode = CMP_LEZ; bus2.a = 32'hFFFFFFFF; bus2.b = 32'd0; bus2.start = 1'b1;
        @(posedge clk); #1 bus2.start = 1'b0;
        k = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus2.done === 1'b1) begin k = c; break; end
        end
        check("full.k", k, 4);
        check("full.res", {29'd0, bus2.eq, bus2.lt, bus2.taken}, {29'd0, 1'b0, 1'b1, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
